vae_buffer_sequencer: RTL

Controller that sequences one per-PE mu/var circular buffer through a job of NUM_TILES tiles. For each tile it runs a mu phase, then a var phase, each PHASE_LEN reads. It drives the buffer's read enable, op mode and clear, and gives the downstream PE a valid/index/last stream aligned to the buffer's one-cycle registered read latency. It sits between the top-level job control (start/done) and a single circular buffer plus PE.

---
 rtl/vae_buffer_sequencer.sv | 83 ++++++++
 1 files changed

// File: rtl/vae_buffer_sequencer.sv
// vae_buffer_sequencer: sequences one mu/var circular buffer through NUM_TILES tiles of mu/var phases; ports: clk, rst (sync active-low), start/mode_sel/stall/abort in, buf_read_en/buf_op_mode/buf_clr to the buffer, pe_valid/pe_mode/pe_elem/pe_last beat to the PE, tile_idx/busy/done status
module vae_buffer_sequencer #(
  parameter int PHASE_LEN = 8,
  parameter int NUM_TILES = 16,
  parameter int TILE_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [1:0] mode_sel,
  input  logic stall,
  input  logic abort,
  output logic buf_read_en,
  output logic buf_op_mode,
  output logic buf_clr,
  output logic pe_valid,
  output logic pe_mode,
  output logic [$clog2(PHASE_LEN)-1:0] pe_elem,
  output logic pe_last,
  output logic [TILE_W-1:0] tile_idx,
  output logic busy,
  output logic done
);
  localparam int EW = $clog2(PHASE_LEN);
  localparam logic [EW-1:0] ELEM_MAX = EW'(PHASE_LEN - 1);
  localparam logic [TILE_W-1:0] TILE_MAX = TILE_W'(NUM_TILES - 1);
  typedef enum logic [2:0] {IDLE, CLEAR, MU, VAR, DRAIN, DONE, FLUSH} state_t;
  state_t state, state_n, first_phase;
  logic [1:0] mode_q;
  logic [EW-1:0] elem;
  logic go, phase_end, last_phase, last_tile;
  assign go = start && (mode_sel != 2'b00);
  assign first_phase = mode_q[0] ? MU : VAR;
  assign phase_end = buf_read_en && (elem == ELEM_MAX);
  assign last_phase = (state == VAR) || !mode_q[1];
  assign last_tile = tile_idx == TILE_MAX;
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = go ? CLEAR : IDLE;
    else if (state == FLUSH) state_n = IDLE;
    else if (abort) state_n = FLUSH;
    else if (state == CLEAR) state_n = first_phase;
    else if (state == DRAIN) state_n = DONE;
    else if (state == DONE) state_n = IDLE;
    else if (phase_end) state_n = (state == MU && mode_q[1]) ? VAR : last_tile ? DRAIN : first_phase;
  end
  always_comb begin
    buf_read_en = ((state == MU) || (state == VAR)) && !stall;
    buf_op_mode = state == VAR;
    buf_clr = (state == CLEAR) || (state == FLUSH);
    busy = state != IDLE;
    done = state == DONE;
  end
  // Beat stage mirrors the buffer's one-cycle registered read; abort kills the beat in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q <= '0;
      elem <= '0;
      tile_idx <= '0;
      pe_valid <= 1'b0;
      pe_mode <= 1'b0;
      pe_elem <= '0;
      pe_last <= 1'b0;
    end else begin
      if (state == IDLE && go) begin
        mode_q <= mode_sel;
        tile_idx <= '0;
        elem <= '0;
      end else if (buf_read_en) begin
        elem <= phase_end ? '0 : elem + 1'b1;
        if (phase_end && last_phase && !last_tile) tile_idx <= tile_idx + 1'b1;
      end
      pe_valid <= buf_read_en && !abort;
      pe_mode <= buf_op_mode;
      pe_elem <= elem;
      pe_last <= buf_read_en && !abort && phase_end && last_phase && last_tile;
    end
  end
endmodule
